// File: rtl/posterior_accumulator.sv
// posterior_accumulator
//   Consumes the likelihood-array output bus (one bit per class row), builds one
//   counter per class, then runs a sequential argmax and reports the winning
//   class with a one-cycle done strobe.
//   Stochastic mode: counts 1s per class over a 2**Nwin cycle window.
//   Log mode: deserialises each class's 2**Nword_used-bit word, MSB first.
//   Optional feature: define POSTACC_COUNTS_EN to add the counts_out port, a
//   snapshot of every class counter taken on entry to DONE.
//   Handshake: start is a level sampled only in IDLE; busy is high from the
//   cycle after acceptance through the done cycle; done is a one-cycle pulse
//   and winner/winner_cnt/tie hold until the next done.
module posterior_accumulator #(
  parameter int  Narray     = 2,
  parameter int  Nword_used = 3,
  parameter int  Nwin       = 8,
  localparam int NCLASS     = 2**Narray,
  localparam int CNT_W      = ((Nwin + 1) > (2**Nword_used)) ? (Nwin + 1) : (2**Nword_used)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stoch_log,
  input  logic [NCLASS-1:0] bit_in,
  output logic              busy,
  output logic              done,
  output logic [Narray-1:0] winner,
  output logic [CNT_W-1:0]  winner_cnt,
  output logic              tie
`ifdef POSTACC_COUNTS_EN
  ,
  output logic [NCLASS*CNT_W-1:0] counts_out
`endif
);

  // Cycle counter must hold the larger of the two window lengths.
  localparam int CYC_W = ((Nwin > Nword_used) ? Nwin : Nword_used) + 1;
  localparam logic [CYC_W-1:0] L_STOCH = CYC_W'(2**Nwin);
  localparam logic [CYC_W-1:0] L_LOG   = CYC_W'(2**Nword_used);
  localparam logic [Narray-1:0] LAST_IDX = Narray'(NCLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q;
  logic               mode_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [Narray-1:0]  idx_q;
  logic [CNT_W-1:0]   cnt_q [NCLASS];
  logic [CNT_W-1:0]   best_q;
  logic [Narray-1:0]  best_idx_q;
  logic               tie_run_q;
  logic               busy_q;
  logic               done_q;
  logic [Narray-1:0]  winner_q;
  logic [CNT_W-1:0]   winner_cnt_q;
  logic               tie_q;

  logic [CNT_W-1:0]   cur_cnt;
  logic [CNT_W-1:0]   best_d;
  logic [Narray-1:0]  best_idx_d;
  logic               tie_d;

`ifdef POSTACC_COUNTS_EN
  logic [NCLASS*CNT_W-1:0] counts_q;
  assign counts_out = counts_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign winner     = winner_q;
  assign winner_cnt = winner_cnt_q;
  assign tie        = tie_q;

  // Argmax step for the class under examination; lower index wins equal values.
  always_comb begin
    cur_cnt    = cnt_q[idx_q];
    best_d     = best_q;
    best_idx_d = best_idx_q;
    tie_d      = tie_run_q;
    if (idx_q == '0) begin
      best_d     = cur_cnt;
      best_idx_d = '0;
      tie_d      = 1'b0;
    end else if (cur_cnt > best_q) begin
      best_d     = cur_cnt;
      best_idx_d = idx_q;
      tie_d      = 1'b0;
    end else if (cur_cnt == best_q) begin
      tie_d      = 1'b1;
    end
  end

  // Control FSM with class counters and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      cyc_q        <= '0;
      idx_q        <= '0;
      for (int k = 0; k < NCLASS; k++) cnt_q[k] <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      tie_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= '0;
      winner_cnt_q <= '0;
      tie_q        <= 1'b0;
`ifdef POSTACC_COUNTS_EN
      counts_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int k = 0; k < NCLASS; k++) cnt_q[k] <= '0;
            mode_q  <= stoch_log;
            cyc_q   <= stoch_log ? L_LOG : L_STOCH;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int k = 0; k < NCLASS; k++) begin
            if (mode_q) cnt_q[k] <= {cnt_q[k][CNT_W-2:0], bit_in[k]};
            else        cnt_q[k] <= cnt_q[k] + CNT_W'(bit_in[k]);
          end
          cyc_q <= cyc_q - 1'b1;
          if (cyc_q == CYC_W'(1)) begin
            idx_q   <= '0;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          tie_run_q  <= tie_d;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            winner_q     <= best_idx_d;
            winner_cnt_q <= best_d;
            tie_q        <= tie_d;
            done_q       <= 1'b1;
`ifdef POSTACC_COUNTS_EN
            for (int k = 0; k < NCLASS; k++) counts_q[k*CNT_W +: CNT_W] <= cnt_q[k];
`endif
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
